mac_frame_sequencer: RTL

- Controller that runs one multiply-accumulate frame on the coefficient/accumulator DSP datapath.
- Per frame it:
  - loads a coefficient into the div4-domain coefficient register,
  - clears the accumulator,
  - streams exactly cfg_len samples through a valid/ready handshake,
  - waits for the pipeline to settle,
  - captures the accumulator as a single result.
- Sits between the sample source/host and the DSP datapath. It is the only driver of the datapath's control pins.

---
 rtl/mac_frame_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mac_frame_sequencer.sv
// mac_frame_sequencer: runs one coefficient-load / clear / stream / drain / capture MAC frame on the DSP datapath
//
// Optional build macro: MAC_FRAME_SEQ_TIMEOUT_EN adds a RUN-state idle timeout that behaves as an abort.
//
// Ports:
//   clk_in, rst_n            fast datapath clock, asynchronous active-low reset
//   start, abort             frame start pulse (IDLE only), synchronous abort (highest priority)
//   cfg_coeff, cfg_len       frame coefficient and sample count, latched on an accepted start
//   s_data, s_valid, s_ready sample stream handshake
//   dp_coeff, dp_coeff_load  datapath coefficient value and its load strobe
//   dp_clear_acc             datapath accumulator clear
//   dp_data, dp_data_valid   registered sample forwarded to the datapath
//   dp_enable                datapath enable, high while a frame is in progress
//   dp_acc                   datapath accumulator readback
//   result, result_valid     captured accumulator and its one-cycle strobe
//   busy, aborted            frame in progress, one-cycle abort/timeout strobe
module mac_frame_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int COEFF_HOLD = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   cfg_coeff,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   dp_coeff,
    output logic                    dp_coeff_load,
    output logic                    dp_clear_acc,
    output logic [DATA_WIDTH-1:0]   dp_data,
    output logic                    dp_data_valid,
    output logic                    dp_enable,
    input  logic [2*DATA_WIDTH-1:0] dp_acc,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    aborted
);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t               state, state_n;
    logic [LEN_WIDTH-1:0] len_r, cnt;
    logic [7:0]           hold_cnt;
    logic                 drain;
    logic                 kill;
    logic                 accept;

    // The coefficient must stay on the pins for a full slow-clock period, and
    // TIMEOUT must be meaningful even in builds that leave it unused.
    if (COEFF_HOLD < 4 || COEFF_HOLD > 255 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mac_frame_sequencer: COEFF_HOLD must be 4..255 and TIMEOUT positive");
    end

    // RUN is left right after the last acceptance, so the count check only
    // guards against an inconsistent len_r.
    assign s_ready       = state == RUN && cnt < len_r;
    assign dp_coeff_load = state == LOAD;
    assign dp_clear_acc  = state == CLEAR;
    assign busy          = state != IDLE;
    assign dp_enable     = busy;

`ifdef MAC_FRAME_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    // Cycles since RUN entry or the last acceptance.
    logic [TW-1:0] tmo;

    assign kill = abort || (s_ready && tmo == TW'(TIMEOUT));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            tmo <= '0;
        else
            tmo <= (state == RUN && state_n == RUN) ? (accept ? TW'(1) : tmo + TW'(1)) : '0;
    end
`else
    assign kill = abort;
`endif

    // A sample handed over in the same cycle as an abort is dropped with the frame.
    assign accept = s_valid && s_ready && !kill;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    if (hold_cnt == 8'(COEFF_HOLD - 1)) state_n = CLEAR;
            CLEAR:   state_n = |len_r ? RUN : DRAIN;
            RUN:     if (accept && cnt == len_r - LEN_WIDTH'(1)) state_n = DRAIN;
            DRAIN:   if (drain) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            len_r         <= '0;
            cnt           <= '0;
            hold_cnt      <= '0;
            drain         <= 1'b0;
            dp_coeff      <= DATA_WIDTH'(1);
            dp_data       <= '0;
            dp_data_valid <= 1'b0;
            result        <= '0;
            result_valid  <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            state         <= state_n;
            hold_cnt      <= (state == LOAD && state_n == LOAD) ? hold_cnt + 8'd1 : '0;
            cnt           <= (state == RUN && state_n == RUN) ? cnt + LEN_WIDTH'(accept) : '0;
            drain         <= state == DRAIN && state_n == DRAIN;
            dp_data_valid <= accept;
            result_valid  <= state == DONE && !kill;
            aborted       <= kill;
            if (state == IDLE && state_n == LOAD) begin
                dp_coeff <= cfg_coeff;
                len_r    <= cfg_len;
            end
            if (accept)
                dp_data <= s_data;
            if (state == DONE && !kill)
                result <= dp_acc;
        end
    end

endmodule
